// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// hazard or flush, and saturating hazard statistics counters.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [13:0]   id_ctrl,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_pc4,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic [4:0]    id_shamt,
    input  logic [5:0]    id_funct,
    input  logic          flush,
    input  logic          hold,
    input  logic          cnt_clr,
    output logic          ex_valid,
    output logic [13:0]   ex_ctrl,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic [4:0]    ex_shamt,
    output logic [5:0]    ex_funct,
    output logic          stall,
    output logic [CW-1:0] bubble_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    logic lu_s;
    logic bubble_s;

    // Load in EX whose destination feeds either ID source; $zero never hazards.
    always_comb begin
        lu_s     = ex_valid & ex_ctrl[9] & (ex_rt != 5'd0) & id_valid &
                   ((ex_rt == id_rs) | (ex_rt == id_rt));
        stall    = lu_s & ~flush & ~hold;
        bubble_s = flush | lu_s;
    end

    // Pipeline register: hold > bubble (flush or load-use) > capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= 14'd0;
            ex_rs_data <= {DW{1'b0}};
            ex_rt_data <= {DW{1'b0}};
            ex_imm     <= {DW{1'b0}};
            ex_pc4     <= {DW{1'b0}};
            ex_rs      <= 5'd0;
            ex_rt      <= 5'd0;
            ex_rd      <= 5'd0;
            ex_shamt   <= 5'd0;
            ex_funct   <= 6'd0;
        end else if (hold) begin
            ex_valid   <= ex_valid;
            ex_ctrl    <= ex_ctrl;
            ex_rs_data <= ex_rs_data;
            ex_rt_data <= ex_rt_data;
            ex_imm     <= ex_imm;
            ex_pc4     <= ex_pc4;
            ex_rs      <= ex_rs;
            ex_rt      <= ex_rt;
            ex_rd      <= ex_rd;
            ex_shamt   <= ex_shamt;
            ex_funct   <= ex_funct;
        end else if (bubble_s) begin
            // Bubble zeroes every field so no enable can leak into later stages.
            ex_valid   <= 1'b0;
            ex_ctrl    <= 14'd0;
            ex_rs_data <= {DW{1'b0}};
            ex_rt_data <= {DW{1'b0}};
            ex_imm     <= {DW{1'b0}};
            ex_pc4     <= {DW{1'b0}};
            ex_rs      <= 5'd0;
            ex_rt      <= 5'd0;
            ex_rd      <= 5'd0;
            ex_shamt   <= 5'd0;
            ex_funct   <= 6'd0;
        end else begin
            ex_valid   <= id_valid;
            ex_ctrl    <= id_valid ? id_ctrl : 14'd0;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_pc4     <= id_pc4;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
            ex_shamt   <= id_shamt;
            ex_funct   <= id_funct;
        end
    end

    // Statistics counters: hold freezes, clear beats increment, flush beats load-use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= {CW{1'b0}};
            flush_cnt  <= {CW{1'b0}};
        end else if (hold) begin
            bubble_cnt <= bubble_cnt;
            flush_cnt  <= flush_cnt;
        end else if (cnt_clr) begin
            bubble_cnt <= {CW{1'b0}};
            flush_cnt  <= {CW{1'b0}};
        end else if (flush) begin
            bubble_cnt <= bubble_cnt;
            flush_cnt  <= sat_inc(flush_cnt);
        end else if (lu_s) begin
            bubble_cnt <= sat_inc(bubble_cnt);
            flush_cnt  <= flush_cnt;
        end else begin
            bubble_cnt <= bubble_cnt;
            flush_cnt  <= flush_cnt;
        end
    end

endmodule
